// File: rtl/muntjac_pkg.sv
// muntjac_pkg: shared front-end types for the fetch engine.
//   if_reason_e    - reason tag carried on instruction-cache fetch requests
//   fetch_state_e  - fetch engine FSM states
//   fetch_entry_t  - one buffered fetch result (pc, instr, compressed, exception)
//   is_compressed  - RVC length decode from the low two instruction bits
package muntjac_pkg;

  localparam int unsigned IF_XLEN = 64;

  typedef enum logic [2:0] {
    IF_PREFETCH     = 3'd0,
    IF_MISPREDICT   = 3'd1,
    IF_PROT_CHANGED = 3'd2,
    IF_SATP_CHANGED = 3'd3,
    IF_FENCE_I      = 3'd4
  } if_reason_e;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STALL,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [31:0]        instr;
    logic               compressed;
    logic               exception;
  } fetch_entry_t;

  // Anything other than 2'b11 in the low bits is a 16-bit encoding.
  function automatic logic is_compressed(input logic [31:0] instr);
    return instr[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_queue_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, rstn      clock, async active-low reset (pointers/count only)
//   flush          drop all entries (wins over enq/deq)
//   enq, enq_data  push one entry
//   deq            pop the head entry
//   head           head entry, read straight from storage
//   count          occupancy, 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
module fetch_queue_fifo
  import muntjac_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             enq,
  input  fetch_entry_t     enq_data,
  input  logic             deq,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem[wr_ptr] <= enq_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: front-end fetch engine. Owns the sequential fetch PC,
// keeps at most one request outstanding to the instruction cache, decodes
// 16/32-bit length of each returned instruction to advance the PC, and
// buffers results in a small queue drained by decode (valid/ready).
// Ports:
//   clk, rstn                     clock, async active-low reset
//   redirect_valid/pc/reason      back-end restart: flush + immediate refetch
//   icache_req_valid/pc/reason    fetch request (combinational)
//   icache_resp_valid/pc/instr/exception  cache response
//   deq_valid/ready/pc/instr/compressed/exception  decode-side queue head
// Build option: FETCH_QUEUE_BYPASS_EN presents a response arriving at an
// empty queue on deq_* in the same cycle (skipping storage if accepted).
// XLEN must equal muntjac_pkg::IF_XLEN (width of fetch_entry_t.pc).
module instr_fetch_queue
  import muntjac_pkg::*;
#(
  parameter int unsigned XLEN  = IF_XLEN,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  if_reason_e      redirect_reason,
  output logic            icache_req_valid,
  output logic [XLEN-1:0] icache_req_pc,
  output if_reason_e      icache_req_reason,
  input  logic            icache_resp_valid,
  input  logic [XLEN-1:0] icache_resp_pc,
  input  logic [31:0]     icache_resp_instr,
  input  logic            icache_resp_exception,
  output logic            deq_valid,
  input  logic            deq_ready,
  output logic [XLEN-1:0] deq_pc,
  output logic [31:0]     deq_instr,
  output logic            deq_compressed,
  output logic            deq_exception
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     state;
  logic [XLEN-1:0]  out_pc;      // outstanding PC (FETCH) or next PC (STALL)
  logic [XLEN-1:0]  redir_pc_al;
  logic [XLEN-1:0]  next_pc;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ_next;
  fetch_entry_t     head, resp_entry, show;
  logic             resp_hit, resp_comp, bypass, room;
  logic             fifo_enq, fifo_deq;

  assign redir_pc_al = {redirect_pc[XLEN-1:1], 1'b0};

  // Only the response matching the outstanding PC counts; a same-cycle
  // redirect discards it.
  assign resp_hit  = icache_resp_valid && !redirect_valid && (state == FETCH) &&
                     (icache_resp_pc == out_pc);
  assign resp_comp = is_compressed(icache_resp_instr);
  assign next_pc   = out_pc + (resp_comp ? XLEN'(2) : XLEN'(4));

  always_comb begin
    resp_entry            = '0;
    resp_entry.pc         = out_pc;
    resp_entry.exception  = icache_resp_exception;
    if (!icache_resp_exception) begin
      resp_entry.instr      = icache_resp_instr;
      resp_entry.compressed = resp_comp;
    end
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = resp_hit && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign show      = bypass ? resp_entry : head;
  assign deq_valid = !redirect_valid && ((count != '0) || bypass);
  assign deq_pc         = show.pc;
  assign deq_instr      = show.instr;
  assign deq_compressed = show.compressed;
  assign deq_exception  = show.exception;

  // A bypassed entry consumed this cycle never touches storage.
  assign fifo_deq = deq_valid && deq_ready && (count != '0);
  assign fifo_enq = resp_hit && !(bypass && deq_ready);

  // Occupancy after this cycle's enq/deq decides whether the next request
  // still has a reserved slot for its response.
  assign occ_next = {1'b0, count} + (CNT_W+1)'(fifo_enq) - (CNT_W+1)'(fifo_deq);
  assign room     = occ_next < (CNT_W+1)'(DEPTH);

  fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (redirect_valid),
    .enq      (fifo_enq),
    .enq_data (resp_entry),
    .deq      (fifo_deq),
    .head     (head),
    .count    (count)
  );

  always_comb begin
    icache_req_valid  = 1'b0;
    icache_req_pc     = out_pc;
    icache_req_reason = IF_PREFETCH;
    if (redirect_valid) begin
      icache_req_valid  = 1'b1;
      icache_req_pc     = redir_pc_al;
      icache_req_reason = redirect_reason;
    end else begin
      case (state)
        FETCH: if (resp_hit && !icache_resp_exception && room) begin
          icache_req_valid = 1'b1;
          icache_req_pc    = next_pc;
        end
        STALL: if (count < CNT_W'(DEPTH)) icache_req_valid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else if (redirect_valid) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH: if (resp_hit) begin
          if (icache_resp_exception) state <= HALT;
          else if (!room)            state <= STALL;
        end
        STALL: if (count < CNT_W'(DEPTH)) state <= FETCH;
        default: state <= state;
      endcase
    end
  end

  // PC has no reset value; it is always written by a redirect before use.
  always_ff @(posedge clk) begin
    if (redirect_valid)
      out_pc <= redir_pc_al;
    else if (resp_hit && !icache_resp_exception)
      out_pc <= next_pc;
  end

  // Slot reservation guarantees a response always has room.
  always_ff @(posedge clk) begin
    if (rstn && fifo_enq) assert (count != CNT_W'(DEPTH));
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
  import muntjac_pkg::*;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clk = 1'b0, rstn = 1'b0;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  if_reason_e      redirect_reason;
  logic            icache_req_valid;
  logic [XLEN-1:0] icache_req_pc;
  if_reason_e      icache_req_reason;
  logic            icache_resp_valid;
  logic [XLEN-1:0] icache_resp_pc;
  logic [31:0]     icache_resp_instr;
  logic            icache_resp_exception;
  logic            deq_valid, deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [31:0]     deq_instr;
  logic            deq_compressed, deq_exception;

  instr_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_reason(redirect_reason),
    .icache_req_valid(icache_req_valid), .icache_req_pc(icache_req_pc),
    .icache_req_reason(icache_req_reason),
    .icache_resp_valid(icache_resp_valid), .icache_resp_pc(icache_resp_pc),
    .icache_resp_instr(icache_resp_instr),
    .icache_resp_exception(icache_resp_exception),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
    .deq_instr(deq_instr), .deq_compressed(deq_compressed),
    .deq_exception(deq_exception)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; one-cycle pulses drop.
  task automatic tick();
    @(posedge clk); #1;
    redirect_valid        = 1'b0;
    icache_resp_valid     = 1'b0;
    icache_resp_exception = 1'b0;
  endtask

  task automatic redir(input logic [63:0] pc, input if_reason_e r);
    redirect_valid = 1'b1; redirect_pc = pc; redirect_reason = r;
  endtask

  task automatic resp(input logic [63:0] pc, input logic [31:0] ins, input logic exc);
    icache_resp_valid = 1'b1; icache_resp_pc = pc;
    icache_resp_instr = ins;  icache_resp_exception = exc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  // Reference model state for the random phase
  fetch_entry_t mq[$];
  fetch_entry_t e;
  logic [63:0]  exp_pc, pend_pc, rp, stale;
  logic [31:0]  rnd, ins;
  logic         outst, halted, exc, comp, do_red, real_resp;
  int           pend_dly, region, deqs;
  logic [63:0]  a [4];

  initial begin
    redirect_valid = 0; redirect_pc = '0; redirect_reason = IF_PREFETCH;
    icache_resp_valid = 0; icache_resp_pc = '0; icache_resp_instr = '0;
    icache_resp_exception = 0; deq_ready = 0;

    // Reset
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_valid", icache_req_valid, 0);
    chk("rst_deq_valid", deq_valid, 0);
    tick(); rstn = 1'b1;
    #1 chk("idle_no_req", icache_req_valid, 0);
    tick();

    // Redirect then 32-bit response
    redir(64'h8000_0000, IF_MISPREDICT); #1;
    chk("redir_req_valid", icache_req_valid, 1);
    chk("redir_req_pc", icache_req_pc, 64'h8000_0000);
    chk("redir_req_reason", icache_req_reason, IF_MISPREDICT);
    tick();
    resp(64'h8000_0000, 32'h0000_0013, 0); #1;
    chk("resp_req_valid", icache_req_valid, 1);
    chk("resp_req_pc", icache_req_pc, 64'h8000_0004);
    chk("resp_req_reason", icache_req_reason, IF_PREFETCH);
`ifndef FETCH_QUEUE_BYPASS_EN
    chk("enq_latency", deq_valid, 0);
`endif
    tick();
    deq_ready = 1; #1;
    chk("deq1_valid", deq_valid, 1);
    chk("deq1_pc", deq_pc, 64'h8000_0000);
    chk("deq1_instr", deq_instr, 32'h13);
    chk("deq1_comp", deq_compressed, 0);
    tick(); deq_ready = 0;

    // Compressed instruction advances by 2
    redir(64'h100, IF_MISPREDICT); #1; tick();
    resp(64'h100, 32'h0000_4501, 0); #1;
    chk("rvc_next_pc", icache_req_pc, 64'h102);
    tick();
    deq_ready = 1; #1;
    chk("rvc_pc", deq_pc, 64'h100);
    chk("rvc_comp", deq_compressed, 1);
    chk("rvc_instr", deq_instr, 32'h4501);
    tick(); deq_ready = 0;

    // Fill to DEPTH with decode stalled, then STALL until a dequeue
    a[0] = 64'h102; a[1] = 64'h106; a[2] = 64'h10a; a[3] = 64'h10e;
    for (int i = 0; i < 4; i++) begin
      resp(a[i], 32'h13, 0); #1;
      if (i < 3) begin
        chk("fill_req_valid", icache_req_valid, 1);
        chk("fill_req_pc", icache_req_pc, a[i] + 4);
      end else begin
        chk("full_no_req", icache_req_valid, 0);
      end
      tick();
    end
    resp(64'h112, 32'h13, 0); #1;
    chk("fifth_no_req", icache_req_valid, 0);
    tick();
    #1 chk("stall_idle_no_req", icache_req_valid, 0);
    tick();
    deq_ready = 1; #1;
    chk("stall_deq_pc", deq_pc, 64'h102);
    chk("stall_no_req_same_cycle", icache_req_valid, 0);
    tick(); deq_ready = 0; #1;
    chk("stall_release_req", icache_req_valid, 1);
    chk("stall_release_pc", icache_req_pc, 64'h112);
    chk("stall_release_reason", icache_req_reason, IF_PREFETCH);
    tick();
    deq_ready = 1;
    for (int i = 1; i < 4; i++) begin
      #1 chk("drain_valid", deq_valid, 1);
      chk("drain_pc", deq_pc, a[i]);
      tick();
    end
    #1 chk("exactly_four", deq_valid, 0);
    tick(); deq_ready = 0;

    // Redirect with an entry queued and a fetch outstanding; late response
    redir(64'h1FC, IF_MISPREDICT); #1; tick();
    resp(64'h1FC, 32'h13, 0); #1;
    chk("pre_stale_req_pc", icache_req_pc, 64'h200);
    tick();
    #1 chk("pre_stale_queued", deq_valid, 1);
    tick();
    redir(64'h1000, IF_FENCE_I); deq_ready = 1; #1;
    chk("redir_deq_suppressed", deq_valid, 0);
    chk("redir2_pc", icache_req_pc, 64'h1000);
    chk("redir2_reason", icache_req_reason, IF_FENCE_I);
    tick();
    resp(64'h200, 32'h13, 0); #1;
    chk("stale_no_req", icache_req_valid, 0);
    chk("flushed_empty", deq_valid, 0);
    tick();
    #1 chk("stale_not_enq", deq_valid, 0);
    tick(); deq_ready = 0;

    // Fetch fault halts fetch
    redir(64'h300, IF_MISPREDICT); #1; tick();
    resp(64'h300, 32'hFFFF_FFFF, 1); #1;
    chk("fault_no_req", icache_req_valid, 0);
    tick();
    deq_ready = 1; #1;
    chk("fault_valid", deq_valid, 1);
    chk("fault_pc", deq_pc, 64'h300);
    chk("fault_exc", deq_exception, 1);
    chk("fault_instr", deq_instr, 0);
    chk("fault_comp", deq_compressed, 0);
    tick(); deq_ready = 0;
    for (int i = 0; i < 3; i++) begin
      resp(64'h300, 32'h13, 0); #1;
      chk("halt_no_req", icache_req_valid, 0);
      tick();
    end
    #1 chk("halt_no_enq", deq_valid, 0);
    tick();

    // Redirect coinciding with a matching response
    redir(64'h400, IF_MISPREDICT); #1; tick();
    resp(64'h400, 32'h13, 0); redir(64'h500, IF_PROT_CHANGED); #1;
    chk("coinc_req_pc", icache_req_pc, 64'h500);
    chk("coinc_reason", icache_req_reason, IF_PROT_CHANGED);
    chk("coinc_deq_valid", deq_valid, 0);
    tick();
    #1 chk("coinc_discarded", deq_valid, 0);
    chk("coinc_single_req", icache_req_valid, 0);
    tick();
    resp(64'h500, 32'h0000_0001, 0); #1;
    chk("coinc_next_pc", icache_req_pc, 64'h502);
    tick();
    deq_ready = 1; #1;
    chk("coinc_deq_pc", deq_pc, 64'h500);
    tick(); deq_ready = 0;

    // Odd redirect PC aligned; PC wraps at 2^64
    redir(64'hFFFF_FFFF_FFFF_FFFF, IF_MISPREDICT); #1;
    chk("odd_redirect_pc", icache_req_pc, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    resp(64'hFFFF_FFFF_FFFF_FFFE, 32'h0000_0001, 0); #1;
    chk("wrap_pc", icache_req_pc, 64'h0);
    tick();
    deq_ready = 1; #1;
    chk("wrap_deq_pc", deq_pc, 64'hFFFF_FFFF_FFFF_FFFE);
    tick(); deq_ready = 0;

    // Reset mid-fetch abandons the request
    redir(64'h600, IF_MISPREDICT); #1; tick();
    rstn = 1'b0; #1;
    chk("midrst_req", icache_req_valid, 0);
    chk("midrst_deq", deq_valid, 0);
    tick(); rstn = 1'b1;
    resp(64'h600, 32'h13, 0); #1;
    chk("post_rst_drop_req", icache_req_valid, 0);
    tick();
    #1 chk("post_rst_drop_enq", deq_valid, 0);
    tick();

    // Random phase against a queue-based reference model
    outst = 0; halted = 0; pend_dly = 0; region = 0; deqs = 0;
    exp_pc = '0; pend_pc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      do_red    = (cyc == 0) || ($urandom_range(0, 39) == 0) ||
                  (halted && $urandom_range(0, 3) == 0);
      real_resp = 0;
      exc       = 0;
      if (outst && pend_dly == 0 && $urandom_range(0, 3) != 0) begin
        real_resp = 1;
        comp = $urandom_range(0, 1) == 1;
        rnd  = $urandom;
        if (comp) begin
          ins = {16'h0, rnd[15:0]};
          if (ins[1:0] == 2'b11) ins[1:0] = 2'b01;
        end else begin
          ins = {rnd[31:2], 2'b11};
        end
        exc = $urandom_range(0, 15) == 0;
        resp(pend_pc, ins, exc);
      end else begin
        if (outst && pend_dly > 0) pend_dly--;
        if ($urandom_range(0, 7) == 0) begin
          stale = 64'hDEAD_0000_0000_0000 | {32'h0, $urandom};
          stale[0] = 1'b0;
          resp(stale, 32'h13, 0);
        end
      end
      deq_ready = $urandom_range(0, 9) < 7;
      if (do_red) begin
        region++;
        rp = 64'h4000_0000 + 64'(region) * 64'h1_0000 + 64'($urandom_range(0, 511));
        redir(rp, ($urandom_range(0, 1) == 1) ? IF_MISPREDICT : IF_FENCE_I);
      end
      #1;
      if (do_red) begin
        chk("rnd_redir_req", icache_req_valid, 1);
        chk("rnd_redir_pc", icache_req_pc, {rp[63:1], 1'b0});
        chk("rnd_redir_reason", icache_req_reason, redirect_reason);
        chk("rnd_redir_deq", deq_valid, 0);
        mq.delete();
        outst    = 1;
        halted   = 0;
        pend_pc  = {rp[63:1], 1'b0};
        pend_dly = $urandom_range(0, 3);
      end else begin
        chk("rnd_deq_valid", deq_valid, (mq.size() != 0));
        if (deq_valid && deq_ready && mq.size() != 0) begin
          e = mq.pop_front();
          chk("rnd_deq_pc", deq_pc, e.pc);
          chk("rnd_deq_instr", deq_instr, e.instr);
          chk("rnd_deq_comp", deq_compressed, e.compressed);
          chk("rnd_deq_exc", deq_exception, e.exception);
          deqs++;
        end
        if (real_resp) begin
          e.pc         = pend_pc;
          e.exception  = exc;
          e.instr      = exc ? 32'h0 : ins;
          e.compressed = exc ? 1'b0 : (ins[1:0] != 2'b11);
          mq.push_back(e);
          outst = 0;
          if (exc) halted = 1;
          else     exp_pc = pend_pc + ((ins[1:0] != 2'b11) ? 64'd2 : 64'd4);
        end
        if (icache_req_valid) begin
          chk("rnd_single_outst", outst, 0);
          chk("rnd_not_halted", halted, 0);
          chk("rnd_req_pc", icache_req_pc, exp_pc);
          chk("rnd_req_reason", icache_req_reason, IF_PREFETCH);
          chk("rnd_slot_free", (mq.size() < DEPTH), 1);
          outst    = 1;
          pend_pc  = exp_pc;
          pend_dly = $urandom_range(0, 3);
        end
      end
      tick();
    end
    chk("rnd_progress", (deqs > 100), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
